// File: rtl/mem_stage_if.sv
// Bundle of EX/MEM inputs and MEM/WB outputs for the MEM pipeline stage.
// The pipeline (or a testbench) drives the master side; mem_stage is the slave.
interface mem_stage_if;
   logic        stall;
   logic        flush;
   logic        forwardM;
   logic        EXMEM_MemRead;
   logic        EXMEM_MemWrite;
   logic        EXMEM_RegWrite;
   logic        EXMEM_MemtoReg;
   logic [1:0]  EXMEM_MemSize;
   logic        EXMEM_MemSigned;
   logic [31:0] EXMEM_ALUResult;
   logic [31:0] EXMEM_StoreData;
   logic [4:0]  EXMEM_RegisterRd;
   logic        MEMWB_RegWrite;
   logic        MEMWB_MemtoReg;
   logic [31:0] MEMWB_ReadData;
   logic [31:0] MEMWB_ALUResult;
   logic [4:0]  MEMWB_RegisterRd;
   logic [31:0] MEMWB_WriteData;
   logic        misalign_err;

   modport master (
      output stall, flush, forwardM,
      output EXMEM_MemRead, EXMEM_MemWrite, EXMEM_RegWrite, EXMEM_MemtoReg,
      output EXMEM_MemSize, EXMEM_MemSigned, EXMEM_ALUResult, EXMEM_StoreData,
      output EXMEM_RegisterRd,
      input  MEMWB_RegWrite, MEMWB_MemtoReg, MEMWB_ReadData, MEMWB_ALUResult,
      input  MEMWB_RegisterRd, MEMWB_WriteData, misalign_err
   );

   modport slave (
      input  stall, flush, forwardM,
      input  EXMEM_MemRead, EXMEM_MemWrite, EXMEM_RegWrite, EXMEM_MemtoReg,
      input  EXMEM_MemSize, EXMEM_MemSigned, EXMEM_ALUResult, EXMEM_StoreData,
      input  EXMEM_RegisterRd,
      output MEMWB_RegWrite, MEMWB_MemtoReg, MEMWB_ReadData, MEMWB_ALUResult,
      output MEMWB_RegisterRd, MEMWB_WriteData, misalign_err
   );
endinterface

// File: rtl/mem_stage.sv
// MIPS MEM stage: data memory with byte/half/word access, store-data forwarding
// from the MEM/WB writeback value, and the MEM/WB pipeline register.
module mem_stage #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   mem_stage_if.slave bus
);
   localparam int         DEPTH   = 2**ADDR_W;
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic        regwrite_q, regwrite_d;
   logic        memtoreg_q, memtoreg_d;
   logic        misalign_q, misalign_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] alu_q, alu_d;
   logic [4:0]  rd_q, rd_d;

   logic [ADDR_W-1:0] word_idx;
   logic [1:0]        lane;
   logic              is_byte, is_half, is_word;
   logic              misaligned;
   logic              fwd_sel;
   logic              mem_we;
   logic [31:0]       wb_data;
   logic [31:0]       store_data;
   logic [3:0]        byte_en;
   logic [31:0]       wr_lanes;
   logic [31:0]       rd_word;
   logic [7:0]        rd_byte;
   logic [15:0]       rd_half;
   logic [31:0]       rd_ext;

   assign word_idx = bus.EXMEM_ALUResult[ADDR_W+1:2];
   assign lane     = bus.EXMEM_ALUResult[1:0];
   assign is_byte  = (bus.EXMEM_MemSize == SZ_BYTE);
   assign is_half  = (bus.EXMEM_MemSize == SZ_HALF);
   assign is_word  = bus.EXMEM_MemSize[1];

   assign misaligned = (bus.EXMEM_MemRead || bus.EXMEM_MemWrite) &&
                       ((is_half && lane[0]) || (is_word && (lane != 2'd0)));

   // forwardM alone is not trusted: a $0 or non-writing WB instruction must not forward
   assign wb_data    = memtoreg_q ? rdata_q : alu_q;
   assign fwd_sel    = bus.forwardM && regwrite_q && (rd_q != 5'd0);
   assign store_data = fwd_sel ? wb_data : bus.EXMEM_StoreData;
   assign mem_we     = bus.EXMEM_MemWrite && !misaligned && !bus.stall;

   always_comb begin
      byte_en  = 4'b1111;
      wr_lanes = store_data;
      if (is_byte) begin
         byte_en  = 4'b0001 << lane;
         wr_lanes = {4{store_data[7:0]}};
      end else if (is_half) begin
         byte_en  = lane[1] ? 4'b1100 : 4'b0011;
         wr_lanes = {2{store_data[15:0]}};
      end
   end

   // Gating on rst_n keeps the array a plain RAM while still blocking a store
   // on the edge where reset is already asserted.
   always_ff @(posedge clk) begin
      if (mem_we && rst_n) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) mem_q[word_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
         end
      end
   end

   assign rd_word = mem_q[word_idx];
   assign rd_byte = rd_word[{lane, 3'b000} +: 8];
   assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

   always_comb begin
      rd_ext = rd_word;
      if (is_byte) begin
         rd_ext = {{24{bus.EXMEM_MemSigned & rd_byte[7]}}, rd_byte};
      end else if (is_half) begin
         rd_ext = {{16{bus.EXMEM_MemSigned & rd_half[15]}}, rd_half};
      end
   end

   always_comb begin
      regwrite_d = bus.EXMEM_RegWrite && !misaligned;
      memtoreg_d = bus.EXMEM_MemtoReg;
      rdata_d    = (bus.EXMEM_MemRead && !misaligned) ? rd_ext : 32'd0;
      alu_d      = bus.EXMEM_ALUResult;
      rd_d       = bus.EXMEM_RegisterRd;
      misalign_d = misaligned;
      if (bus.flush) begin
         regwrite_d = 1'b0;
         memtoreg_d = 1'b0;
         rdata_d    = 32'd0;
         alu_d      = 32'd0;
         rd_d       = 5'd0;
         misalign_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regwrite_q <= 1'b0;
         memtoreg_q <= 1'b0;
         rdata_q    <= 32'd0;
         alu_q      <= 32'd0;
         rd_q       <= 5'd0;
         misalign_q <= 1'b0;
      end else if (!bus.stall) begin
         regwrite_q <= regwrite_d;
         memtoreg_q <= memtoreg_d;
         rdata_q    <= rdata_d;
         alu_q      <= alu_d;
         rd_q       <= rd_d;
         misalign_q <= misalign_d;
      end
   end

   assign bus.MEMWB_RegWrite   = regwrite_q;
   assign bus.MEMWB_MemtoReg   = memtoreg_q;
   assign bus.MEMWB_ReadData   = rdata_q;
   assign bus.MEMWB_ALUResult  = alu_q;
   assign bus.MEMWB_RegisterRd = rd_q;
   assign bus.MEMWB_WriteData  = wb_data;
   assign bus.misalign_err     = misalign_q;
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios with literal expectations plus random
// traffic, all compared every cycle against a word-array reference model.
module tb_mem_stage;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_stage_if bus();
   mem_stage #(.ADDR_W(8), .DATA_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   logic [31:0] ref_mem [256];
   logic        e_rw, e_mtr, e_mis;
   logic [31:0] e_rdata, e_alu;
   logic [4:0]  e_rd;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      e_rw = 0; e_mtr = 0; e_mis = 0; e_rdata = 0; e_alu = 0; e_rd = 0;
   endtask

   // Reference: memory is a plain word array, loads/stores use shift-and-mask arithmetic.
   task automatic model_step();
      logic [7:0]  idx;
      logic [1:0]  ln, sz;
      bit          half, word, byt, mis, fwd;
      logic [31:0] a, old, val, sd, mask, wb;
      int          sh;
      if (!rst_n || bus.stall) return;
      a    = bus.EXMEM_ALUResult;
      idx  = a[9:2];
      ln   = a[1:0];
      sz   = bus.EXMEM_MemSize;
      byt  = (sz == 2'd0);
      half = (sz == 2'd1);
      word = (sz >= 2'd2);
      mis  = (bus.EXMEM_MemRead || bus.EXMEM_MemWrite) &&
             ((half && ln[0]) || (word && ln != 2'd0));
      old  = ref_mem[idx];
      if (byt) begin
         val = (old >> (8 * ln)) & 32'hFF;
         if (bus.EXMEM_MemSigned && val[7]) val = val | 32'hFFFFFF00;
      end else if (half) begin
         val = (old >> (16 * ln[1])) & 32'hFFFF;
         if (bus.EXMEM_MemSigned && val[15]) val = val | 32'hFFFF0000;
      end else begin
         val = old;
      end
      wb  = e_mtr ? e_rdata : e_alu;
      fwd = bus.forwardM && e_rw && (e_rd != 0);
      sd  = fwd ? wb : bus.EXMEM_StoreData;
      if (bus.EXMEM_MemWrite && !mis) begin
         if (byt) begin
            sh = 8 * ln;
            mask = 32'hFF << sh;
            ref_mem[idx] = (old & ~mask) | ((sd & 32'hFF) << sh);
         end else if (half) begin
            sh = 16 * ln[1];
            mask = 32'hFFFF << sh;
            ref_mem[idx] = (old & ~mask) | ((sd & 32'hFFFF) << sh);
         end else begin
            ref_mem[idx] = sd;
         end
      end
      if (bus.flush) begin
         model_reset();
      end else begin
         e_rw    = bus.EXMEM_RegWrite && !mis;
         e_mtr   = bus.EXMEM_MemtoReg;
         e_rdata = (bus.EXMEM_MemRead && !mis) ? val : 32'd0;
         e_alu   = a;
         e_rd    = bus.EXMEM_RegisterRd;
         e_mis   = mis;
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("regwrite",  {31'd0, bus.MEMWB_RegWrite}, {31'd0, e_rw});
         chk("memtoreg",  {31'd0, bus.MEMWB_MemtoReg}, {31'd0, e_mtr});
         chk("readdata",  bus.MEMWB_ReadData, e_rdata);
         chk("aluresult", bus.MEMWB_ALUResult, e_alu);
         chk("rd",        {27'd0, bus.MEMWB_RegisterRd}, {27'd0, e_rd});
         chk("writedata", bus.MEMWB_WriteData, e_mtr ? e_rdata : e_alu);
         chk("misalign",  {31'd0, bus.misalign_err}, {31'd0, e_mis});
      end
   end

   task automatic set_in(input bit rd, input bit wr, input bit rw, input bit mtr,
                         input logic [1:0] sz, input bit sgn, input logic [31:0] a,
                         input logic [31:0] sd, input logic [4:0] rdn, input bit fwd,
                         input bit stl, input bit fls);
      bus.EXMEM_MemRead    = rd;
      bus.EXMEM_MemWrite   = wr;
      bus.EXMEM_RegWrite   = rw;
      bus.EXMEM_MemtoReg   = mtr;
      bus.EXMEM_MemSize    = sz;
      bus.EXMEM_MemSigned  = sgn;
      bus.EXMEM_ALUResult  = a;
      bus.EXMEM_StoreData  = sd;
      bus.EXMEM_RegisterRd = rdn;
      bus.forwardM         = fwd;
      bus.stall            = stl;
      bus.flush            = fls;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic sw(input logic [31:0] a, input logic [31:0] d);
      set_in(0, 1, 0, 0, 2'd2, 0, a, d, 5'd0, 0, 0, 0); tick();
   endtask

   task automatic ld(input logic [1:0] sz, input bit sgn, input logic [31:0] a, input logic [4:0] rdn);
      set_in(1, 0, 1, 1, sz, sgn, a, 32'd0, rdn, 0, 0, 0); tick();
   endtask

   task automatic nop();
      set_in(0, 0, 0, 0, 2'd0, 0, 32'd0, 32'd0, 5'd0, 0, 0, 0); tick();
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_rw"},  {31'd0, bus.MEMWB_RegWrite}, 32'd0);
      chk({nm, "_mtr"}, {31'd0, bus.MEMWB_MemtoReg}, 32'd0);
      chk({nm, "_rd"},  bus.MEMWB_ReadData, 32'd0);
      chk({nm, "_alu"}, bus.MEMWB_ALUResult, 32'd0);
      chk({nm, "_rdn"}, {27'd0, bus.MEMWB_RegisterRd}, 32'd0);
      chk({nm, "_wd"},  bus.MEMWB_WriteData, 32'd0);
      chk({nm, "_mis"}, {31'd0, bus.misalign_err}, 32'd0);
   endtask

   initial begin : main
      logic [31:0] a;
      logic [1:0]  sz;
      int          kind;
      bit          rd, wr, rw;
      model_reset();
      set_in(0, 0, 0, 0, 2'd0, 0, 32'd0, 32'd0, 5'd0, 0, 0, 0);
      #3;
      chk_all_zero("reset");
      @(negedge clk);
      rst_n  = 1'b1;
      chk_en = 1'b1;

      for (int i = 0; i < 256; i++) sw(i * 4, $urandom);

      sw(32'h10, 32'hDEADBEEF);
      ld(2'd2, 0, 32'h10, 5'd5);
      chk("lw_data", bus.MEMWB_ReadData, 32'hDEADBEEF);
      chk("lw_rd",   {27'd0, bus.MEMWB_RegisterRd}, 32'd5);
      chk("lw_rw",   {31'd0, bus.MEMWB_RegWrite}, 32'd1);

      sw(32'h20, 32'h11223344);
      set_in(0, 1, 0, 0, 2'd0, 0, 32'h21, 32'h000000AA, 5'd0, 0, 0, 0); tick();
      ld(2'd0, 1, 32'h21, 5'd6);
      chk("lb_signed", bus.MEMWB_ReadData, 32'hFFFFFFAA);
      ld(2'd0, 0, 32'h21, 5'd6);
      chk("lbu", bus.MEMWB_ReadData, 32'h000000AA);
      ld(2'd2, 0, 32'h20, 5'd6);
      chk("lw_merged", bus.MEMWB_ReadData, 32'h1122AA44);

      sw(32'h20, 32'h80015555);
      ld(2'd1, 1, 32'h22, 5'd7);
      chk("lh_signed", bus.MEMWB_ReadData, 32'hFFFF8001);
      set_in(0, 1, 0, 0, 2'd1, 0, 32'h23, 32'h0000BEEF, 5'd0, 0, 0, 0); tick();
      chk("sh_mis", {31'd0, bus.misalign_err}, 32'd1);
      ld(2'd2, 0, 32'h21, 5'd8);
      chk("lw_mis",    {31'd0, bus.misalign_err}, 32'd1);
      chk("lw_mis_rw", {31'd0, bus.MEMWB_RegWrite}, 32'd0);
      chk("lw_mis_rd", bus.MEMWB_ReadData, 32'd0);
      nop();
      chk("mis_pulse", {31'd0, bus.misalign_err}, 32'd0);
      ld(2'd2, 0, 32'h20, 5'd8);
      chk("mis_nowrite", bus.MEMWB_ReadData, 32'h80015555);

      sw(32'h30, 32'h12345678);
      ld(2'd2, 0, 32'h30, 5'd3);
      set_in(0, 1, 0, 0, 2'd2, 0, 32'h40, 32'hBAD0BAD0, 5'd0, 1, 0, 0); tick();
      ld(2'd2, 0, 32'h40, 5'd4);
      chk("fwd_used", bus.MEMWB_ReadData, 32'h12345678);
      ld(2'd2, 0, 32'h30, 5'd0);
      set_in(0, 1, 0, 0, 2'd2, 0, 32'h44, 32'h0000ABCD, 5'd0, 1, 0, 0); tick();
      ld(2'd2, 0, 32'h44, 5'd4);
      chk("fwd_r0", bus.MEMWB_ReadData, 32'h0000ABCD);

      for (int s = 0; s < 2; s++) begin
         set_in(0, 1, 0, 0, 2'd2, 0, 32'h50, 32'h55AA55AA, 5'd0, 0, 1, 0); tick();
         chk("stall_hold", bus.MEMWB_ReadData, 32'h0000ABCD);
      end
      ld(2'd2, 0, 32'h50, 5'd4);
      chk("stall_nowrite", bus.MEMWB_ReadData, ref_mem[8'h14]);
      set_in(0, 1, 0, 0, 2'd2, 0, 32'h50, 32'h55AA55AA, 5'd0, 0, 0, 0); tick();
      ld(2'd2, 0, 32'h50, 5'd4);
      chk("stall_release", bus.MEMWB_ReadData, 32'h55AA55AA);

      set_in(0, 0, 1, 0, 2'd0, 0, 32'h7, 32'd0, 5'd9, 0, 0, 1); tick();
      chk("flush_rw",  {31'd0, bus.MEMWB_RegWrite}, 32'd0);
      chk("flush_alu", bus.MEMWB_ALUResult, 32'd0);
      set_in(0, 0, 1, 0, 2'd0, 0, 32'h7, 32'd0, 5'd9, 0, 0, 0); tick();
      chk("add_wd", bus.MEMWB_WriteData, 32'h7);
      set_in(0, 1, 0, 0, 2'd2, 0, 32'h60, 32'h00000077, 5'd0, 0, 0, 1); tick();
      ld(2'd2, 0, 32'h60, 5'd2);
      chk("flush_write", bus.MEMWB_ReadData, 32'h00000077);

      set_in(0, 1, 0, 0, 2'd2, 0, 32'h10, 32'hCAFEF00D, 5'd0, 0, 0, 0);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk_all_zero("midreset");
      tick();
      rst_n = 1'b1;
      ld(2'd2, 0, 32'h10, 5'd5);
      chk("reset_preserve", bus.MEMWB_ReadData, 32'hDEADBEEF);

      for (int i = 0; i < 2000; i++) begin
         kind = $urandom_range(0, 2);
         sz   = 2'($urandom_range(0, 3));
         a    = $urandom;
         if ($urandom_range(0, 4) != 0) begin
            if (sz == 2'd1) a[0] = 1'b0;
            if (sz[1]) a[1:0] = 2'b00;
         end
         rd = (kind == 0);
         wr = (kind == 1);
         if ($urandom_range(0, 19) == 0) begin rd = 1; wr = 1; end
         rw = (kind != 1) && ($urandom_range(0, 7) != 0);
         set_in(rd, wr, rw, rd, sz, 1'($urandom_range(0, 1)), a, $urandom,
                ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0,
                $urandom_range(0, 9) == 0);
         tick();
      end

      for (int i = 0; i < 256; i++) begin
         ld(2'd2, 0, i * 4, 5'd1);
      end
      nop();
      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MIPS pipeline MEM stage: owns the data memory, performs lw/lh/lb/sw/sh/sb for the instruction in EX/MEM, and registers results into the MEM/WB pipeline register.
- Consumes the store-data forwarding select from the memory forwarding unit; the MEM/WB writeback value it produces is the forwarding source.
- Sits between the EX/MEM register and the writeback mux.

Parameters:
- ADDR_W, 8, word-address width; memory depth = 2**ADDR_W 32-bit words
- DATA_W, 32, datapath width (fixed 32 in this design; byte/half logic assumes 32)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold MEM/WB outputs and suppress memory write this cycle
- flush  in  1  load a bubble into MEM/WB this cycle
- EXMEM_MemRead  in  1  load instruction in MEM
- EXMEM_MemWrite  in  1  store instruction in MEM
- EXMEM_RegWrite  in  1  instruction writes a register
- EXMEM_MemtoReg  in  1  writeback selects memory data
- EXMEM_MemSize  in  2  00 byte, 01 half, 10 word, 11 treated as word
- EXMEM_MemSigned  in  1  sign-extend lb/lh
- EXMEM_ALUResult  in  32  effective address or ALU result
- EXMEM_StoreData  in  32  rt value read in ID
- EXMEM_RegisterRd  in  5  destination register (rt for loads)
- forwardM  in  1  select MEM/WB writeback value as store data
- MEMWB_RegWrite  out  1  registered
- MEMWB_MemtoReg  out  1  registered
- MEMWB_ReadData  out  32  registered, extended load data
- MEMWB_ALUResult  out  32  registered
- MEMWB_RegisterRd  out  5  registered; also drives the forwarding unit's MEMWB_RegisterRt input
- MEMWB_WriteData  out  32  combinational: MemtoReg ? ReadData : ALUResult
- misalign_err  out  1  registered, one-cycle pulse

Behaviour:
- Reset (rst_n=0, async): all MEMWB_* registers and misalign_err = 0. Memory array not cleared.
- Word index = ALUResult[ADDR_W+1:2]; upper address bits ignored (wrap-around). Little-endian byte lanes.
- Store data = (forwardM && MEMWB_RegWrite && MEMWB_RegisterRd!=0) ? MEMWB_WriteData : EXMEM_StoreData. The gating on RegWrite and $0 is required even though forwardM does not check either condition.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0, when MemRead or MemWrite.
  - No memory write.
  - MEMWB_RegWrite=0 and MEMWB_ReadData=0 on the next edge.
  - misalign_err=1 for exactly that cycle.
- Write: at rising edge when MemWrite && !misaligned && !stall. Only the addressed lanes are written:
  - sb: lane addr[1:0] gets data[7:0]
  - sh: lanes addr[1]*2 and +1 get data[15:0]
  - sw: all four lanes
- Read: combinational array read of the word, then lane selection and extension:
  - lb: byte addr[1:0]
  - lh: half addr[1]
  - signed uses sign-extension, else zero-extension
  - result registered into MEMWB_ReadData at the edge; load latency is 1 cycle (data visible in WB the cycle after MEM).
- A store at edge N followed by a load to the same word in MEM during cycle N+1 returns the new data; no internal bypass needed.
- Simultaneous MemRead and MemWrite: write takes place; ReadData captures the pre-write word.
- stall=1: MEMWB_* and misalign_err hold their values; no write; ignores flush.
- flush=1 (stall=0): MEMWB_RegWrite=0, MEMWB_MemtoReg=0, others 0; the memory write for the current instruction still occurs.
- Non-memory instruction: ALUResult, RegWrite, MemtoReg, Rd pass through with 1-cycle latency; ReadData=0.
- Reset asserted mid-store: a write at the same edge as reset assertion must not occur; async reset has priority.

Test Plan:
- Reset then sw of 0xDEADBEEF to addr 0x10, then lw addr 0x10 with Rd=5 -> MEMWB_ReadData=0xDEADBEEF, RegisterRd=5, RegWrite=1 one cycle after lw in MEM.
- sw 0x11223344 @0x20; sb 0xAA @0x21; lb signed @0x21 -> 0xFFFFFFAA; lbu @0x21 -> 0x000000AA; lw @0x20 -> 0x1122AA44.
- lh signed @0x22 after word 0x8001xxxx -> 0xFFFF8001; sh @0x23 -> misalign_err=1 one cycle, memory unchanged, MEMWB_RegWrite=0.
- Store-data forwarding:
  - lw r3 (ReadData 0x12345678) in WB with sw r3 in MEM, forwardM=1 -> memory gets 0x12345678, not the stale StoreData.
  - Repeat with MEMWB_RegisterRd=0 -> StoreData used.
- stall=1 for 2 cycles during sw -> no write, MEMWB_* frozen; release -> exactly one write, outputs advance.
- flush=1 with RegWrite add result 0x7 -> MEMWB_RegWrite=0; rst_n low mid-sequence -> all outputs 0 immediately, prior memory contents preserved.
